// File: rtl/syscall_unit.sv
// syscall_unit: decode-stage syscall service engine.
// Handles print-int, print-char, print-string (byte-wise reads from data
// memory) and exit. The pipeline is frozen via stall while a service runs.
// Every service ends in a one-cycle DONE state with stall low, so the
// pipeline moves past the syscall instruction before another can be accepted.
module syscall_unit #(
  parameter int MEM_LAT = 1,
  parameter int MAX_STR = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall_d,
  input  logic [31:0] instr_d,
  input  logic [31:0] a0,
  input  logic [31:0] v0,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  output logic [31:0] out_data,
  output logic        out_is_int,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        stall,
  output logic        busy,
  output logic        halt
);

  // Wait counter only needs to reach MEM_LAT-1; the char counter must reach MAX_STR.
  localparam int WW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
  localparam int CW = $clog2(MAX_STR + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INT,
    S_CHAR,
    S_STR_FETCH,
    S_STR_WAIT,
    S_STR_EMIT,
    S_DONE,
    S_HALTED
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            out_is_int_q, out_is_int_d;
  logic            out_valid_q, out_valid_d;
  logic            halt_q, halt_d;
  logic [31:0]     ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wait_q, wait_d;

  logic            accept;
  logic [7:0]      rbyte;
  logic [31:0]     ptr_inc;
  logic [CW-1:0]   cnt_inc;

  // Only the function/opcode fields identify SYSCALL; the rest of the word is don't-care.
  logic unused_instr;
  assign unused_instr = ^instr_d[25:6];

  assign accept  = (state_q == S_IDLE) && syscall_d &&
                   (instr_d[31:26] == 6'd0) && (instr_d[5:0] == 6'h0C);
  assign ptr_inc = ptr_q + 32'd1;
  assign cnt_inc = cnt_q + CW'(1);

  // Big-endian byte lane select from the returned word.
  always_comb begin
    rbyte = 8'h00;
    case (ptr_q[1:0])
      2'd0: rbyte = mem_rdata[31:24];
      2'd1: rbyte = mem_rdata[23:16];
      2'd2: rbyte = mem_rdata[15:8];
      default: rbyte = mem_rdata[7:0];
    endcase
  end

  // Next-state and next-output computation for the service FSM.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = 1'b0;
    out_data_d   = out_data_q;
    out_is_int_d = out_is_int_q;
    out_valid_d  = out_valid_q;
    halt_d       = halt_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (v0 == 32'd1) begin
            state_d      = S_INT;
            out_data_d   = a0;
            out_is_int_d = 1'b1;
            out_valid_d  = 1'b1;
          end else if (v0 == 32'd11) begin
            state_d      = S_CHAR;
            out_data_d   = {24'h0, a0[7:0]};
            out_is_int_d = 1'b0;
            out_valid_d  = 1'b1;
          end else if (v0 == 32'd4) begin
            // mem_req is registered, so the request is raised on entry to FETCH.
            state_d    = S_STR_FETCH;
            ptr_d      = a0;
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = {a0[31:2], 2'b00};
          end else if (v0 == 32'd10) begin
            state_d = S_HALTED;
            halt_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_INT, S_CHAR: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_STR_FETCH: begin
        state_d = S_STR_WAIT;
        wait_d  = '0;
      end
      S_STR_WAIT: begin
        if (wait_q == WW'(MEM_LAT - 1)) begin
          if (rbyte == 8'h00) begin
            state_d = S_DONE;
          end else begin
            state_d      = S_STR_EMIT;
            out_data_d   = {24'h0, rbyte};
            out_is_int_d = 1'b0;
            out_valid_d  = 1'b1;
          end
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_STR_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ptr_d       = ptr_inc;
          cnt_d       = cnt_inc;
          if (cnt_inc == CW'(MAX_STR)) begin
            state_d = S_DONE;
          end else begin
            // Each character is refetched; no word caching.
            state_d    = S_STR_FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = {ptr_inc[31:2], 2'b00};
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any service and drops pending output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= 32'd0;
      mem_req_q    <= 1'b0;
      out_data_q   <= 32'd0;
      out_is_int_q <= 1'b0;
      out_valid_q  <= 1'b0;
      halt_q       <= 1'b0;
      ptr_q        <= 32'd0;
      cnt_q        <= '0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      out_data_q   <= out_data_d;
      out_is_int_q <= out_is_int_d;
      out_valid_q  <= out_valid_d;
      halt_q       <= halt_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
    end
  end

  // Stall covers the accept cycle itself and every state except IDLE and DONE.
  always_comb begin
    if (state_q == S_IDLE) stall = accept;
    else                   stall = (state_q != S_DONE);
  end

  assign busy       = (state_q != S_IDLE);
  assign mem_addr   = mem_addr_q;
  assign mem_req    = mem_req_q;
  assign out_data   = out_data_q;
  assign out_is_int = out_is_int_q;
  assign out_valid  = out_valid_q;
  assign halt       = halt_q;

endmodule

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Consumes the decode-stage syscall interface: the syscall flag, the instruction, and the a0/v0 register values.
- Executes the requested service as a multi-cycle FSM and freezes the pipeline with stall while it works.
- Services: print integer, print character, print null-terminated string (byte reads from data memory), and exit.
- Sits beside the hazard unit. Its stall is ORed into the fetch/decode stall; its output channel drives the simulation console.

Parameters:
- MEM_LAT, 1: cycles from mem_req assertion to valid mem_rdata (≥1).
- MAX_STR, 256: maximum characters emitted per print-string; stops early at this limit.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- syscall_d  in  1  decode-stage syscall control signal
- instr_d  in  32  decode-stage instruction
- a0  in  32  register $a0 (argument / string pointer)
- v0  in  32  register $v0 (service code)
- mem_addr  out  32  word-aligned byte address for string reads
- mem_req  out  1  one-cycle read request
- mem_rdata  in  32  read data, valid MEM_LAT cycles after mem_req
- out_data  out  32  integer value, or character in [7:0] with upper bits 0
- out_is_int  out  1  1 = out_data is an integer, 0 = character
- out_valid  out  1  output item valid
- out_ready  in  1  console accepts the item when out_valid && out_ready
- stall  out  1  freeze PC and IF/ID register
- busy  out  1  FSM not in IDLE
- halt  out  1  exit executed; sticky until reset

Behaviour:
- Reset: state=IDLE. mem_addr=0, mem_req=0, out_data=0, out_is_int=0, out_valid=0, stall=0, busy=0, halt=0, pointer=0, char count=0. Reset mid-operation aborts the service and discards any pending item.
- Accept condition: state==IDLE && syscall_d && instr_d[31:26]==0 && instr_d[5:0]==6'h0C. syscall_d with a non-matching encoding is ignored.
- stall is combinational:
  - 1 in IDLE when the accept condition holds.
  - 1 in INT, CHAR, STR_FETCH, STR_WAIT, STR_EMIT and HALTED.
  - 0 in IDLE (otherwise) and in DONE.
- Service dispatch on accept, using v0 latched at accept:
  - v0==1: INT, with out_data=a0, out_is_int=1.
  - v0==11: CHAR, with out_data={24'h0,a0[7:0]}, out_is_int=0.
  - v0==4: STR_FETCH, pointer=a0, count=0.
  - v0==10: HALTED.
  - Any other value: DONE, with no side effect.
- INT / CHAR:
  - out_valid=1 and out_data held stable until out_ready.
  - On handshake: out_valid=0, go to DONE.
- STR_FETCH:
  - mem_req=1 for one cycle, mem_addr={pointer[31:2],2'b00}.
  - Go to STR_WAIT with a wait counter.
- STR_WAIT:
  - Count MEM_LAT cycles after mem_req, then capture the byte. Big-endian select: offset 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0].
  - Byte==0: go to DONE with nothing emitted.
  - Otherwise: go to STR_EMIT with out_data={24'h0,byte}, out_valid=1.
- STR_EMIT:
  - Hold until out_ready.
  - On handshake: pointer+=1 (32-bit wrap), count+=1.
  - count==MAX_STR: go to DONE; otherwise go to STR_FETCH.
- Each character is refetched individually; no word caching.
- DONE:
  - Lasts one cycle with stall=0, so the pipeline advances past the syscall.
  - syscall_d is ignored in DONE, so the same syscall is never re-accepted.
  - Next state: IDLE.
- HALTED: halt=1 and stall=1 from the cycle after accept. Terminal until reset.
- busy = (state != IDLE).
- out_valid never drops without a handshake except on reset.

Test Plan:
- Print int: v0=1, a0=32'hFFFFFFFB, out_ready=1.
  - Stall high at the accept cycle and the next cycle.
  - out_valid one cycle with out_data=FFFFFFFB and out_is_int=1.
  - DONE next cycle (stall=0), then IDLE.
- Print char with backpressure: v0=11, a0=32'h1234_5641, out_ready low for 3 cycles.
  - out_data=32'h41 held stable with out_valid=1 and stall=1 for 4 cycles.
  - Completes on the handshake.
- Print string: memory word at 0x100 = 32'h48_69_21_00 ("Hi!"), a0=0x100, MEM_LAT=1.
  - Emits 0x48, 0x69, 0x21, then ends on the null.
  - Exactly 4 mem_req pulses, all with mem_addr=0x100.
  - Stall released only after the null.
- MAX_STR limit: MAX_STR=4, string at 0x200 has no null in its first 8 bytes.
  - Exactly 4 characters emitted, then DONE.
- Exit and ignore:
  - v0=10: halt=1 and stall=1 forever; a later syscall_d is ignored.
  - v0=5: one-cycle stall, no output.
  - syscall_d=1 with instr_d=32'h0000000D: ignored.
- Reset mid-string: assert reset during STR_EMIT with out_valid=1.
  - Next cycle all outputs are 0 and state is IDLE.
  - A new v0=11 syscall then completes normally.
